// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the bit-counter width helper.
package serial_adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Counter must reach WIDTH without wrapping, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder used as the serial bit slice: two half-adder
// stages with their carries merged by an OR.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;
    logic g_ab;
    logic g_pc;

    assign p    = a ^ b;
    assign g_ab = a & b;
    assign s    = p ^ cin;
    assign g_pc = p & cin;
    assign cout = g_ab | g_pc;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are added LSB-first through one
// full-adder slice with a registered carry; result after WIDTH cycles.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start; sum/cout hold the last result
// RUN     | one bit per clock, sum shifts in from the top
// DONE    | one-cycle done pulse, then back to IDLE unconditionally
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] sum_shift;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (bit_s),
        .cout (bit_c)
    );

    // A 1-bit sum register has no upper bits to shift down.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_shift = bit_s;
        end else begin : g_sum_wn
            assign sum_shift = {bit_s, sum[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum   <= sum_shift;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= bit_c;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        cout  <= bit_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: a WIDTH=8 and a WIDTH=1 instance,
// a vector table plus hand-written ignore/abort sequences.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8;
    logic [7:0] a8, b8, sum8;
    logic       busy8, done8, cout8;
    logic       start1, a1, b1, sum1, busy1, done1, cout1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       c;
    } vec_t;

    vec_t vecs[8];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; launches one add and follows it to the first IDLE cycle.
    task automatic op8(input logic [7:0] ai, input logic [7:0] bi,
                       input logic [7:0] es, input logic ec,
                       input string nm, input bit chk_shift, input logic [7:0] prev);
        int         done_n;
        int         busy_n;
        logic       busy_at_done;
        logic [15:0] t;
        a8 = ai; b8 = bi; start8 = 1'b1;
        done_n = 0; busy_n = 0; busy_at_done = 1'b1;
        for (int n = 1; n <= 20 && done_n == 0; n++) begin
            @(negedge clk);
            if (n == 1) start8 = 1'b0;
            if (busy8) busy_n++;
            if (chk_shift && n <= 9) begin
                t = ({8'h00, prev} >> (n - 1)) | ({8'h00, es} << (9 - n));
                chk({nm, " partial sum"}, 32'(sum8), 32'(t[7:0]));
                chk({nm, " carry"}, 32'(dut8.carry), 32'd0);
            end
            if (done8) begin
                done_n = n;
                busy_at_done = busy8;
            end
        end
        chk({nm, " done latency"}, done_n, 9);
        chk({nm, " busy cycles"}, busy_n, 8);
        chk({nm, " busy at done"}, 32'(busy_at_done), 32'd0);
        chk({nm, " sum"}, 32'(sum8), 32'(es));
        chk({nm, " cout"}, 32'(cout8), 32'(ec));
        @(negedge clk);
        chk({nm, " done single pulse"}, 32'(done8), 32'd0);
        chk({nm, " sum held"}, 32'(sum8), 32'(es));
    endtask

    task automatic op1(input logic ai, input logic bi, input logic es, input logic ec,
                       input string nm);
        int done_n;
        int busy_n;
        a1 = ai; b1 = bi; start1 = 1'b1;
        done_n = 0; busy_n = 0;
        for (int n = 1; n <= 10 && done_n == 0; n++) begin
            @(negedge clk);
            if (n == 1) start1 = 1'b0;
            if (busy1) busy_n++;
            if (done1) done_n = n;
        end
        chk({nm, " done latency"}, done_n, 2);
        chk({nm, " busy cycles"}, busy_n, 1);
        chk({nm, " sum"}, 32'(sum1), 32'(es));
        chk({nm, " cout"}, 32'(cout1), 32'(ec));
        @(negedge clk);
        chk({nm, " done single pulse"}, 32'(done1), 32'd0);
    endtask

    initial begin
        logic [7:0] prev;
        int         done_seen;

        vecs[0] = '{a: 8'h05, b: 8'h03, s: 8'h08, c: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, s: 8'hFE, c: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'h00, s: 8'h00, c: 1'b0};
        vecs[4] = '{a: 8'h7F, b: 8'h01, s: 8'h80, c: 1'b0};
        vecs[5] = '{a: 8'h80, b: 8'h7F, s: 8'hFF, c: 1'b0};
        vecs[6] = '{a: 8'hC3, b: 8'h3D, s: 8'h00, c: 1'b1};
        vecs[7] = '{a: 8'h9A, b: 8'h6B, s: 8'h05, c: 1'b1};

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy8", 32'(busy8), 32'd0);
        chk("reset done8", 32'(done8), 32'd0);
        chk("reset sum8", 32'(sum8), 32'd0);
        chk("reset cout8", 32'(cout8), 32'd0);
        chk("reset carry8", 32'(dut8.carry), 32'd0);
        chk("reset cnt8", 32'(dut8.cnt), 32'd0);
        chk("reset state8", 32'(dut8.state), 32'd0);
        chk("reset busy1", 32'(busy1), 32'd0);
        chk("reset done1", 32'(done1), 32'd0);
        chk("reset sum1", 32'(sum1), 32'd0);
        chk("reset cout1", 32'(cout1), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        prev = 8'h00;
        for (int i = 0; i < 8; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, $sformatf("vec%0d", i), 1'b0, prev);
            prev = vecs[i].s;
        end

        op8(8'hAA, 8'h55, 8'hFF, 1'b0, "aa_55", 1'b1, prev);

        // start during RUN and during DONE must be ignored
        a8 = 8'h40; b8 = 8'h02; start8 = 1'b1;
        done_seen = 0;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (n == 1) start8 = 1'b0;
            if (n == 3) begin
                chk("ign busy in run", 32'(busy8), 32'd1);
                a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
            end
            if (n == 4) start8 = 1'b0;
            if (done8) done_seen = n;
            if (n == 9) start8 = 1'b1;
        end
        chk("ign done latency", done_seen, 9);
        chk("ign sum at done", 32'(sum8), 32'h42);
        @(negedge clk);
        start8 = 1'b0;
        chk("ign idle busy", 32'(busy8), 32'd0);
        chk("ign idle done", 32'(done8), 32'd0);
        chk("ign idle sum", 32'(sum8), 32'h42);
        chk("ign idle cout", 32'(cout8), 32'd0);
        op8(8'h11, 8'h22, 8'h33, 1'b0, "first_idle_start", 1'b0, 8'h42);

        // abort mid-RUN
        a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) start8 = 1'b0;
        end
        chk("abort pre sum", 32'(sum8), 32'h06);
        chk("abort pre busy", 32'(busy8), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort sum", 32'(sum8), 32'd0);
        chk("abort cout", 32'(cout8), 32'd0);
        chk("abort busy", 32'(busy8), 32'd0);
        chk("abort done", 32'(done8), 32'd0);
        chk("abort carry", 32'(dut8.carry), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done8 || busy8) done_seen++;
        end
        chk("abort no done", done_seen, 0);
        op8(8'h80, 8'h80, 8'h00, 1'b1, "after_abort", 1'b0, 8'h00);

        op1(1'b1, 1'b1, 1'b0, 1'b1, "w1 1+1");
        op1(1'b1, 1'b0, 1'b1, 1'b0, "w1 1+0");
        op1(1'b0, 1'b0, 1'b0, 1'b0, "w1 0+0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
